// File: rtl/ir_nec_key_decoder.sv
// NEC IR receiver: measures mark/space lengths in half-unit ticks and turns a valid
// frame with command 0..15 into a single-cycle one-hot key pulse.
//
// state      | meaning
// IDLE       | line idle, waiting for the leader mark to start
// LEAD_MARK  | inside the 9 ms leader mark
// LEAD_SPACE | inside the leader space (data or repeat)
// BIT_MARK   | inside a 562 us bit mark
// BIT_SPACE  | inside a bit space, its length gives the data bit
// CHECK      | all 32 bits captured, validate address and checksums
module ir_nec_key_decoder #(
    parameter int          TICK_CYCLES = 14063,
    parameter logic [7:0]  ADDR        = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_rx,
    output logic [15:0] ir_in_p1,
    output logic        key_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        CHECK
    } state_t;

    state_t         state_q, state_d;
    logic           sync1_q, sync2_q, rx_dly_q;
    logic [PW-1:0]  presc_q, presc_d;
    logic [5:0]     tick_cnt_q, tick_cnt_d;
    logic [4:0]     bit_cnt_q, bit_cnt_d;
    logic [31:0]    shift_q, shift_d;
    logic [15:0]    ir_in_p1_q, ir_in_p1_d;
    logic           key_valid_q, key_valid_d;
    logic           frame_err_q, frame_err_d;

    logic           edge_det, fall, rise, tick, timeout;
    logic [5:0]     dur;
    logic [7:0]     f_addr, f_addr_n, f_cmd, f_cmd_n;

    function automatic logic in_win(input logic [5:0] v, input logic [5:0] lo,
                                    input logic [5:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rx_dly_q    <= 1'b1;
            presc_q     <= '0;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            state_q     <= IDLE;
            ir_in_p1_q  <= '0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= ir_rx;
            sync2_q     <= sync1_q;
            rx_dly_q    <= sync2_q;
            presc_q     <= presc_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            state_q     <= state_d;
            ir_in_p1_q  <= ir_in_p1_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // The tick landing in the edge cycle still belongs to the level that just ended.
    always_comb begin
        edge_det = sync2_q ^ rx_dly_q;
        fall     = edge_det & ~sync2_q;
        rise     = edge_det & sync2_q;
        tick     = (presc_q == PRESC_MAX);
        dur      = (tick && tick_cnt_q != 6'd63) ? tick_cnt_q + 6'd1 : tick_cnt_q;
        timeout  = (state_q != IDLE) && (tick_cnt_q >= 6'd40);

        presc_d    = (edge_det || tick) ? '0 : presc_q + PW'(1);
        tick_cnt_d = edge_det ? 6'd0 : dur;
    end

    always_comb begin
        f_addr   = shift_q[7:0];
        f_addr_n = shift_q[15:8];
        f_cmd    = shift_q[23:16];
        f_cmd_n  = shift_q[31:24];

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ir_in_p1_d  = '0;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;

        if (timeout) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fall) state_d = LEAD_MARK;
                end
                LEAD_MARK: begin
                    if (rise) begin
                        if (in_win(dur, 6'd28, 6'd36)) begin
                            state_d = LEAD_SPACE;
                        end else begin
                            state_d     = IDLE;
                            frame_err_d = 1'b1;
                        end
                    end
                end
                LEAD_SPACE: begin
                    if (fall) begin
                        if (in_win(dur, 6'd14, 6'd18)) begin
                            state_d   = BIT_MARK;
                            bit_cnt_d = '0;
                        end else if (in_win(dur, 6'd6, 6'd10)) begin
                            state_d = IDLE;
                        end else begin
                            state_d     = IDLE;
                            frame_err_d = 1'b1;
                        end
                    end
                end
                BIT_MARK: begin
                    if (rise) begin
                        if (in_win(dur, 6'd1, 6'd3)) begin
                            state_d = BIT_SPACE;
                        end else begin
                            state_d     = IDLE;
                            frame_err_d = 1'b1;
                        end
                    end
                end
                BIT_SPACE: begin
                    if (fall) begin
                        if (in_win(dur, 6'd1, 6'd3) || in_win(dur, 6'd5, 6'd7)) begin
                            shift_d = {in_win(dur, 6'd5, 6'd7), shift_q[31:1]};
                            if (bit_cnt_q == 5'd31) begin
                                state_d = CHECK;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 5'd1;
                                state_d   = BIT_MARK;
                            end
                        end else begin
                            state_d     = IDLE;
                            frame_err_d = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    state_d = IDLE;
                    if (f_addr == ADDR && (f_addr ^ f_addr_n) == 8'hFF &&
                        (f_cmd ^ f_cmd_n) == 8'hFF) begin
                        if (f_cmd[7:4] == 4'd0) begin
                            ir_in_p1_d  = 16'(1) << f_cmd[3:0];
                            key_valid_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ir_in_p1  = ir_in_p1_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule
